// File: rtl/psum_accum_drain_if.sv
// Psum stream interface: column psum vector in, one-column-per-beat drain out.
interface psum_accum_drain_if #(
  parameter int NUM_COLS     = 14,
  parameter int DATA_WIDTH   = 32,
  parameter int COL_ID_WIDTH = 4
);
  logic [DATA_WIDTH-1:0]   psum_in_vec [0:NUM_COLS-1];
  logic                    psum_in_valid;
  logic                    psum_in_ready;
  logic [DATA_WIDTH-1:0]   out_data;
  logic [COL_ID_WIDTH-1:0] out_col;
  logic                    out_valid;
  logic                    out_ready;

  // Producer/consumer side (grid + global buffer)
  modport master (
    output psum_in_vec, psum_in_valid, out_ready,
    input  psum_in_ready, out_data, out_col, out_valid
  );

  // Accumulate/drain block side
  modport slave (
    input  psum_in_vec, psum_in_valid, out_ready,
    output psum_in_ready, out_data, out_col, out_valid
  );
endinterface

// File: rtl/psum_accum_drain.sv
// Psum output buffer for the PE grid: accumulates N column-psum vectors into
// per-column accumulators, then drains them one column per valid/ready beat.

// One column accumulator: clear on job start, add on each accepted pass.
module psum_acc_lane #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  add_en,
  input  logic [DATA_WIDTH-1:0] psum,
  output logic [DATA_WIDTH-1:0] acc
);
  logic [DATA_WIDTH-1:0] acc_d, acc_q;

  // Next accumulator value; wraps modulo 2^DATA_WIDTH
  always_comb begin
    acc_d = acc_q;
    if (clr)         acc_d = '0;
    else if (add_en) acc_d = acc_q + psum;
  end

  // Accumulator register
  always_ff @(posedge clk) begin
    if (rst) acc_q <= '0;
    else     acc_q <= acc_d;
  end

  assign acc = acc_q;
endmodule

module psum_accum_drain #(
  parameter int NUM_COLS     = 14,
  parameter int DATA_WIDTH   = 32,
  parameter int PASS_WIDTH   = 4,
  parameter int COL_ID_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [PASS_WIDTH-1:0] cfg_num_passes,
  psum_accum_drain_if.slave     bus,
  output logic                  busy,
  output logic                  done
);
  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN} state_t;

  localparam logic [COL_ID_WIDTH-1:0] LAST_COL = COL_ID_WIDTH'(NUM_COLS-1);

  state_t                  state_d, state_q;
  logic [PASS_WIDTH-1:0]   pass_cnt_d, pass_cnt_q;
  logic [PASS_WIDTH-1:0]   num_passes_d, num_passes_q;
  logic [COL_ID_WIDTH-1:0] col_idx_d, col_idx_q;
  logic [DATA_WIDTH-1:0]   out_data_d, out_data_q;
  logic                    done_d, done_q;
  logic                    acc_clr, acc_add;
  logic [COL_ID_WIDTH-1:0] next_col;

  logic [NUM_COLS-1:0][DATA_WIDTH-1:0] acc;

  genvar g;
  generate
    for (g = 0; g < NUM_COLS; g++) begin : g_lane
      psum_acc_lane #(.DATA_WIDTH(DATA_WIDTH)) u_lane (
        .clk    (clk),
        .rst    (rst),
        .clr    (acc_clr),
        .add_en (acc_add),
        .psum   (bus.psum_in_vec[g]),
        .acc    (acc[g])
      );
    end
  endgenerate

  assign next_col = col_idx_q + 1'b1;

  // Sequencer: job start, pass counting, drain column stepping and done pulse.
  // out_data is registered; on the final pass it is loaded with the column-0
  // sum being written this cycle so the first drain beat needs no bubble.
  always_comb begin
    state_d      = state_q;
    pass_cnt_d   = pass_cnt_q;
    num_passes_d = num_passes_q;
    col_idx_d    = col_idx_q;
    out_data_d   = out_data_q;
    done_d       = 1'b0;
    acc_clr      = 1'b0;
    acc_add      = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          acc_clr      = 1'b1;
          num_passes_d = (cfg_num_passes == '0) ? PASS_WIDTH'(1) : cfg_num_passes;
          pass_cnt_d   = '0;
          state_d      = ACCUM;
        end
      end
      ACCUM: begin
        if (bus.psum_in_valid) begin
          acc_add    = 1'b1;
          pass_cnt_d = pass_cnt_q + 1'b1;
          if (pass_cnt_q == num_passes_q - 1'b1) begin
            state_d    = DRAIN;
            col_idx_d  = '0;
            out_data_d = acc[0] + bus.psum_in_vec[0];
          end
        end
      end
      DRAIN: begin
        if (bus.out_ready) begin
          if (col_idx_q == LAST_COL) begin
            state_d    = IDLE;
            col_idx_d  = '0;
            out_data_d = '0;
            done_d     = 1'b1;
          end else begin
            col_idx_d  = next_col;
            out_data_d = acc[next_col];
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      pass_cnt_q   <= '0;
      num_passes_q <= PASS_WIDTH'(1);
      col_idx_q    <= '0;
      out_data_q   <= '0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      pass_cnt_q   <= pass_cnt_d;
      num_passes_q <= num_passes_d;
      col_idx_q    <= col_idx_d;
      out_data_q   <= out_data_d;
      done_q       <= done_d;
    end
  end

  assign busy              = (state_q != IDLE);
  assign bus.psum_in_ready = (state_q == ACCUM);
  assign bus.out_valid     = (state_q == DRAIN);
  assign bus.out_data      = out_data_q;
  assign bus.out_col       = col_idx_q;
  assign done              = done_q;
endmodule
